// File: rtl/tx_byte_fifo_pkg.sv
// Shared types and constants for the UART transmit byte FIFO.
// Issue FSM encoding and the start-acknowledge timeout.
package tx_byte_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } tx_state_e;

  localparam int unsigned START_TO = 4;

endpackage

// File: rtl/tx_byte_fifo_if.sv
// Producer / transmitter side signals of the transmit byte FIFO.
// slave is the FIFO side, master is the environment side.
interface tx_byte_fifo_if #(
  parameter int DEPTH = 16
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [ADDR_W:0] count;
  logic          overflow;
  logic          tx_err;
  logic [7:0]    tx_data;
  logic          tx_new;
  logic          tx_busy;
  logic          tx_block;

  modport slave (
    input  wr_data, wr_en, tx_busy, tx_block,
    output full, empty, count, overflow,
    output tx_err, tx_data, tx_new
  );

  modport master (
    output wr_data, wr_en, tx_busy, tx_block,
    input  full, empty, count, overflow,
    input  tx_err, tx_data, tx_new
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 register-array FIFO with registered pointers and count.
// count is ADDR_W+1 bits so full and empty are never ambiguous.
module sync_fifo_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     rd_en_i,
  output logic [7:0]               rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

  assign push = wr_en_i & ~full_o;
  assign pop  = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (wr_en_i & full_o);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/tx_byte_fifo.sv
// Byte FIFO plus issue FSM feeding the UART serial transmitter.
// Issues one byte per tx_new pulse when the link is idle and unblocked.
module tx_byte_fifo
  import tx_byte_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  tx_byte_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  tx_state_e     state_q, state_d;
  logic [1:0]    timer_q, timer_d;
  logic [1:0]    blk_hist_q, blk_hist_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_new_q, tx_new_d;
  logic          tx_err_q, tx_err_d;
  logic          issue, guard;
  logic          full, empty, overflow;
  logic [ADDR_W:0] count;
  logic [7:0]    rd_data;

  sync_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (issue),
    .rd_data_o  (rd_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  // blk_hist covers the transmitter's two-cycle block-to-busy lag
  assign guard = ~empty & ~bus.tx_busy & ~bus.tx_block
               & (blk_hist_q == 2'b00);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_new_d   = 1'b0;
    tx_err_d   = tx_err_q;
    issue      = 1'b0;
    blk_hist_d = {blk_hist_q[0], bus.tx_block};
    unique case (state_q)
      IDLE: begin
        if (guard) begin
          issue     = 1'b1;
          tx_data_d = rd_data;
          tx_new_d  = 1'b1;
          timer_d   = '0;
          state_d   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == 2'(START_TO - 1)) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      blk_hist_q <= 2'b11;
      tx_data_q  <= 8'h00;
      tx_new_q   <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      blk_hist_q <= blk_hist_d;
      tx_data_q  <= tx_data_d;
      tx_new_q   <= tx_new_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count;
  assign bus.overflow = overflow;
  assign bus.tx_err   = tx_err_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_new   = tx_new_q;

endmodule
